// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage
// Fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
//
// Owns the PC, drives the instruction-memory address, and latches
// {PC+4, instruction, valid} into IF/ID. It exports the Rs/Rt fields that
// the load-use hazard unit compares.
//
// Control inputs have no valid/ready handshake; they are level-sampled on
// every rising edge:
//   - PcLoad=1 lets the PC advance; PcLoad=0 holds the PC.
//   - IFIDLoad=1 lets IF/ID capture; IFIDLoad=0 holds IF/ID.
//   - BranchTaken=1 redirects the PC to BranchTarget and flushes IF/ID.
//     It overrides both load enables for that edge.
//
// Optional build macro FETCH_PERF_CNT_EN adds two saturating 16-bit
// performance counters, StallCnt and FlushCnt.

module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PcLoad,
    input  logic        IFIDLoad,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] InstIn,
    output logic [31:0] InstAddr,
    output logic [31:0] PcIFID,
    output logic [31:0] InstIFID,
    output logic        ValidIFID,
    output logic [4:0]  RsIFID,
    output logic [4:0]  RtIFID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_ifid_q, pc_ifid_d;
    logic [31:0] inst_ifid_q, inst_ifid_d;
    logic        valid_ifid_q, valid_ifid_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    // PC+4 wraps modulo 2^32; the word-aligned redirect drops BranchTarget[1:0]
    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = {BranchTarget[31:2], 2'b00};

    // Next PC: a redirect beats PcLoad; otherwise the PC holds
    always_comb begin
        pc_d = pc_q;
        if (BranchTaken) begin
            pc_d = redirect_pc;
        end else if (PcLoad) begin
            pc_d = pc_plus4;
        end
    end

    // Next IF/ID: a flush inserts a NOP bubble; otherwise capture or hold
    always_comb begin
        pc_ifid_d    = pc_ifid_q;
        inst_ifid_d  = inst_ifid_q;
        valid_ifid_d = valid_ifid_q;
        if (BranchTaken) begin
            pc_ifid_d    = 32'd0;
            inst_ifid_d  = 32'd0;
            valid_ifid_d = 1'b0;
        end else if (IFIDLoad) begin
            pc_ifid_d    = pc_plus4;
            inst_ifid_d  = InstIn;
            valid_ifid_d = 1'b1;
        end
    end

    // PC and IF/ID registers; reset discards any in-flight stall or redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            pc_ifid_q    <= 32'd0;
            inst_ifid_q  <= 32'd0;
            valid_ifid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pc_ifid_q    <= pc_ifid_d;
            inst_ifid_q  <= inst_ifid_d;
            valid_ifid_q <= valid_ifid_d;
        end
    end

    assign InstAddr  = pc_q;
    assign PcIFID    = pc_ifid_q;
    assign InstIFID  = inst_ifid_q;
    assign ValidIFID = valid_ifid_q;
    assign RsIFID    = inst_ifid_q[25:21];
    assign RtIFID    = inst_ifid_q[20:16];

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Stalls count edges where IF/ID holds; flushes count only squashed real instructions
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!BranchTaken && !IFIDLoad && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (BranchTaken && valid_ifid_q && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Saturating counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed testbench for if_id_fetch_stage with RESET_PC = 32'h100.
// The instruction memory model returns an address-tagged word, so every
// expected IF/ID instruction can be written directly from its fetch address.

module tb_if_id_fetch_stage;

  logic        clk;
  logic        rst;
  logic        pc_load;
  logic        ifid_load;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] inst_in;
  logic [31:0] inst_addr;
  logic [31:0] pc_ifid;
  logic [31:0] inst_ifid;
  logic        valid_ifid;
  logic [4:0]  rs_ifid;
  logic [4:0]  rt_ifid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  if_id_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst          (rst),
    .PcLoad       (pc_load),
    .IFIDLoad     (ifid_load),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .InstIn       (inst_in),
    .InstAddr     (inst_addr),
    .PcIFID       (pc_ifid),
    .InstIFID     (inst_ifid),
    .ValidIFID    (valid_ifid),
    .RsIFID       (rs_ifid),
    .RtIFID       (rt_ifid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .StallCnt     (stall_cnt),
    .FlushCnt     (flush_cnt)
`endif
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instruction memory model: address-tagged words, combinational read
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign inst_in = mem_word(inst_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // apply controls, then advance one edge and sample 1 ns later
  task automatic drive(input logic r, input logic pl, input logic il,
                       input logic bt, input logic [31:0] tgt);
    rst           = r;
    pc_load       = pl;
    ifid_load     = il;
    branch_taken  = bt;
    branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_pcifid, input logic [31:0] e_inst,
                              input logic e_valid);
    logic [31:0] ei;
    ei = e_inst;
    check({tag, ".pc"},    inst_addr,          e_pc);
    check({tag, ".pcifid"}, pc_ifid,           e_pcifid);
    check({tag, ".inst"},  inst_ifid,          ei);
    check({tag, ".valid"}, {31'd0, valid_ifid}, {31'd0, e_valid});
    check({tag, ".rs"},    {27'd0, rs_ifid},   {27'd0, ei[25:21]});
    check({tag, ".rt"},    {27'd0, rt_ifid},   {27'd0, ei[20:16]});
  endtask

  initial begin
    rst = 1'b1; pc_load = 1'b0; ifid_load = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0;

    // reset state
    drive(1, 1, 1, 1, 32'h0000_0400);
    expect_state("reset", 32'h100, 32'h0, 32'h0, 1'b0);

    // straight-line fetch
    drive(0, 1, 1, 0, 32'h0);
    expect_state("fetch1", 32'h104, 32'h104, mem_word(32'h100), 1'b1);
    drive(0, 1, 1, 0, 32'h0);
    expect_state("fetch2", 32'h108, 32'h108, mem_word(32'h104), 1'b1);

    // load-use stall at PC=0x108, then resume with no skip or duplicate
    drive(0, 0, 0, 0, 32'h0);
    expect_state("stall", 32'h108, 32'h108, mem_word(32'h104), 1'b1);
    drive(0, 1, 1, 0, 32'h0);
    expect_state("resume", 32'h10C, 32'h10C, mem_word(32'h108), 1'b1);

    // taken branch with misaligned target bits
    drive(0, 1, 1, 1, 32'h0000_0203);
    expect_state("branch", 32'h200, 32'h0, 32'h0, 1'b0);
    drive(0, 1, 1, 0, 32'h0);
    expect_state("target", 32'h204, 32'h204, mem_word(32'h200), 1'b1);

    // redirect concurrent with stall: redirect wins, stall forgotten
    drive(0, 0, 0, 1, 32'h0000_0300);
    expect_state("br_stall", 32'h300, 32'h0, 32'h0, 1'b0);
    drive(0, 1, 1, 0, 32'h0);
    expect_state("br_after", 32'h304, 32'h304, mem_word(32'h300), 1'b1);

    // mismatched load enables honoured literally
    drive(0, 1, 0, 0, 32'h0);
    expect_state("pc_only", 32'h308, 32'h304, mem_word(32'h300), 1'b1);
    drive(0, 0, 1, 0, 32'h0);
    expect_state("ifid_only", 32'h308, 32'h30C, mem_word(32'h308), 1'b1);

    // PC wrap at top of address space
    drive(0, 1, 1, 1, 32'hFFFF_FFFF);
    expect_state("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    drive(0, 1, 1, 0, 32'h0);
    expect_state("wrap", 32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1);

    // reset during a stall discards everything
    drive(1, 0, 0, 0, 32'h0);
    expect_state("mid_rst", 32'h100, 32'h0, 32'h0, 1'b0);
    drive(0, 1, 1, 0, 32'h0);
    expect_state("post_rst", 32'h104, 32'h104, mem_word(32'h100), 1'b1);

`ifdef FETCH_PERF_CNT_EN
    // performance counters: 3 stalls, one real flush, one flush of a bubble
    drive(1, 0, 0, 0, 32'h0);
    check("cnt_rst.stall", {16'd0, stall_cnt}, 32'd0);
    check("cnt_rst.flush", {16'd0, flush_cnt}, 32'd0);
    drive(0, 1, 1, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    check("cnt_stall3", {16'd0, stall_cnt}, 32'd3);
    drive(0, 1, 1, 1, 32'h0000_0500);
    drive(0, 1, 1, 1, 32'h0000_0600);
    check("cnt.stall", {16'd0, stall_cnt}, 32'd3);
    check("cnt.flush", {16'd0, flush_cnt}, 32'd1);
    drive(1, 0, 0, 1, 32'h0);
    check("cnt_mid_rst.stall", {16'd0, stall_cnt}, 32'd0);
    check("cnt_mid_rst.flush", {16'd0, flush_cnt}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
